rv32i_program_driver: RTL and testbench
=======================================

RV32I_PROGRAM_DRIVER -- requirements
Module: rv32i_program_driver

Interface
REQ-001 Parameter XLEN, default 32: instruction width in bits.
REQ-002 Parameter DEPTH, default 16: program store depth in words; power of two, at least 2.
REQ-003 Parameter RST_HOLD, default 2: number of cycles core_rst is held low after start; at least 1.
REQ-004 Parameter LOOP, default 0: 1 wraps the program back to word 0 at its end; 0 stops after one pass.
REQ-005 Parameter NOP, default 32'h00000013: word driven on instruction when not running.
REQ-006 clk  in  1  single clock; all state updates on the rising edge.
REQ-007 rst  in  1  synchronous, active-low reset of the whole block.
REQ-008 load_valid  in  1  a program word is presented this cycle.
REQ-009 load_addr  in  $clog2(DEPTH)  word index of the presented program word.
REQ-010 load_data  in  XLEN  program word to store.
REQ-011 load_ready  out  1  load is accepted when load_valid and load_ready are both high.
REQ-012 start  in  1  single-cycle request to reset the core and run the loaded program.
REQ-013 stall  in  1  hold the current instruction and index while high.
REQ-014 core_rst  out  1  active-low reset to the microprocessor; registered.
REQ-015 instruction  out  XLEN  instruction presented to the microprocessor.
REQ-016 pc_idx  out  $clog2(DEPTH)  index of the word currently presented; registered.
REQ-017 done  out  1  high in DONE state.

Function
REQ-018 FSM states: IDLE, HOLD, RUN, DONE; encoding is free.
REQ-019 A word count register holds max(load_addr)+1 over all accepted loads since reset; reset value 0.
REQ-020 load_ready is high only in IDLE and DONE.
  - An accepted load writes mem[load_addr] on the edge.
  - A load to an existing address overwrites that word and leaves count unchanged unless the address is higher.
REQ-021 IDLE/DONE -> HOLD on start when count != 0; start with count == 0 is ignored.
  - On this edge: core_rst <= 0, hold counter <= RST_HOLD-1, pc_idx <= 0.
REQ-022 A load and start in the same cycle are both performed; that word is visible in RUN.
REQ-023 HOLD: the hold counter decrements each cycle.
  - On the cycle it reads 0, the block moves to RUN and core_rst <= 1.
  - core_rst is therefore low for exactly RST_HOLD cycles.
REQ-024 RUN: instruction = mem[pc_idx]; in all other states instruction = NOP.
  - instruction is a combinational read from registered state; no extra latency.
REQ-025 RUN with stall low and pc_idx < count-1: pc_idx increments each cycle.
REQ-026 RUN with stall low and pc_idx == count-1:
  - LOOP=1: pc_idx <= 0 and the block stays in RUN.
  - LOOP=0: the block moves to DONE with pc_idx unchanged.
REQ-027 RUN with stall high: pc_idx, state and instruction are held; stall is ignored outside RUN.
REQ-028 start during HOLD or RUN is ignored; a run is never restarted mid-flight.
REQ-029 pc_idx arithmetic is modulo DEPTH; with count == DEPTH, index DEPTH-1 wraps or ends exactly per REQ-026.

Reset
REQ-030 With rst low at a rising edge, the block sets:
  - state = IDLE, count = 0, pc_idx = 0, hold counter = 0
  - core_rst = 0, done = 0, instruction = NOP
REQ-031 Memory contents are not reset; count = 0 makes them unreachable.
REQ-032 rst low during HOLD or RUN aborts the run on the same edge; core_rst goes low and stays low until start.

Structure
REQ-033 A shared package holds the FSM state typedef, the default NOP constant and the default XLEN.
REQ-034 The program store is one sub-module, rv32i_prog_mem: DEPTH x XLEN, one synchronous write port, one asynchronous read port.
REQ-035 The FSM, hold counter, count and pc_idx live in the top module.

Verification
REQ-036 Load 3 words (0x00500093, 0x00108113, 0x002081B3), then start -> core_rst low 2 cycles; instruction shows those 3 words over the next 3 cycles, then NOP; done = 1.
REQ-037 LOOP=1, same 3 words, 8 RUN cycles -> pc_idx sequence 0,1,2,0,1,2,0,1.
REQ-038 Stall high for 2 cycles while pc_idx = 1 -> instruction stays 0x00108113 for 3 cycles; total run length grows by 2.
REQ-039 start with no loads -> state stays IDLE, core_rst stays 0, instruction = NOP.
REQ-040 rst low in the 2nd RUN cycle -> next edge: IDLE, pc_idx = 0, count = 0; a new start is ignored until a reload.
REQ-041 DEPTH=4, load all 4 words, LOOP=0 -> pc_idx 0..3, then DONE; load to address 3 while DONE is accepted.

Source files
------------

// File: rtl/rv32i_program_driver_pkg.sv
// rv32i_program_driver_pkg: shared FSM state type and interface defaults
package rv32i_program_driver_pkg;
  typedef enum logic [1:0] {IDLE, HOLD, RUN, DONE} state_t;
  localparam int XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;
endpackage

// File: rtl/rv32i_program_driver_prog_mem.sv
// rv32i_prog_mem: DEPTH x XLEN program store, synchronous write, asynchronous read
module rv32i_prog_mem
  import rv32i_program_driver_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [XLEN-1:0]          rdata
);
  logic [XLEN-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/rv32i_program_driver.sv
// rv32i_program_driver: loads a program, resets the core, then streams the program as instructions
module rv32i_program_driver
  import rv32i_program_driver_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int DEPTH = 16,
  parameter int RST_HOLD = 2,
  parameter int LOOP = 0,
  parameter logic [XLEN-1:0] NOP = XLEN'(NOP_DEFAULT)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load_valid,
  input  logic [$clog2(DEPTH)-1:0] load_addr,
  input  logic [XLEN-1:0]          load_data,
  output logic                     load_ready,
  input  logic                     start,
  input  logic                     stall,
  output logic                     core_rst,
  output logic [XLEN-1:0]          instruction,
  output logic [$clog2(DEPTH)-1:0] pc_idx,
  output logic                     done
);
  localparam int AW = $clog2(DEPTH);
  localparam int HW = $clog2(RST_HOLD) + 1;
  localparam logic [HW-1:0] HOLD_INIT = HW'(RST_HOLD - 1);
  state_t state_q, state_d;
  logic [AW:0] count_q, count_d;
  logic [AW-1:0] pc_idx_q, pc_idx_d;
  logic [HW-1:0] hold_q, hold_d;
  logic core_rst_q, core_rst_d;
  logic [XLEN-1:0] rd_data;
  logic load_fire, go, last;
  assign load_fire = load_valid && load_ready;
  assign go = start && load_ready && count_q != '0;
  assign last = {1'b0, pc_idx_q} == count_q - (AW+1)'(1);
  rv32i_prog_mem #(.XLEN(XLEN), .DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (load_fire),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(pc_idx_q),
    .rdata(rd_data)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      pc_idx_q   <= '0;
      hold_q     <= '0;
      core_rst_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      pc_idx_q   <= pc_idx_d;
      hold_q     <= hold_d;
      core_rst_q <= core_rst_d;
    end
  end
  always_comb begin
    state_d    = state_q;
    count_d    = load_fire && {1'b0, load_addr} >= count_q ? {1'b0, load_addr} + (AW+1)'(1) : count_q;
    pc_idx_d   = pc_idx_q;
    hold_d     = hold_q;
    core_rst_d = core_rst_q;
    case (state_q)
      IDLE, DONE: if (go) begin
        state_d    = HOLD;
        hold_d     = HOLD_INIT;
        pc_idx_d   = '0;
        core_rst_d = 1'b0;
      end
      HOLD: if (hold_q == '0) begin
        state_d    = RUN;
        core_rst_d = 1'b1;
      end else hold_d = hold_q - HW'(1);
      RUN: if (!stall) begin
        if (!last) pc_idx_d = pc_idx_q + AW'(1);
        else if (LOOP != 0) pc_idx_d = '0;
        else state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    load_ready  = state_q == IDLE || state_q == DONE;
    done        = state_q == DONE;
    instruction = state_q == RUN ? rd_data : NOP;
  end
  assign core_rst = core_rst_q;
  assign pc_idx = pc_idx_q;
endmodule

// File: tb/tb_rv32i_program_driver.sv
// tb_rv32i_program_driver: three driver configurations checked against a run-level reference model
module tb_rv32i_program_driver;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, load_valid, start, stall, c_load_valid;
  logic [3:0] load_addr;
  logic [31:0] load_data;
  logic [2:0] rdy, crst, dn;
  logic [31:0] instr_a, instr_b, instr_c;
  logic [3:0] pc_a, pc_b;
  logic [1:0] pc_c;
  assign c_load_valid = load_valid && load_addr < 4'd4;
  rv32i_program_driver #(.DEPTH(16), .RST_HOLD(2), .LOOP(0)) u_once (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(rdy[0]), .start(start), .stall(stall), .core_rst(crst[0]),
    .instruction(instr_a), .pc_idx(pc_a), .done(dn[0]));
  rv32i_program_driver #(.DEPTH(16), .RST_HOLD(2), .LOOP(1)) u_loop (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .load_ready(rdy[1]), .start(start), .stall(stall), .core_rst(crst[1]),
    .instruction(instr_b), .pc_idx(pc_b), .done(dn[1]));
  rv32i_program_driver #(.DEPTH(4), .RST_HOLD(3), .LOOP(0)) u_small (
    .clk(clk), .rst(rst), .load_valid(c_load_valid), .load_addr(load_addr[1:0]), .load_data(load_data),
    .load_ready(rdy[2]), .start(start), .stall(stall), .core_rst(crst[2]),
    .instruction(instr_c), .pc_idx(pc_c), .done(dn[2]));
  int checks = 0, errors = 0;
  logic [31:0] mm [3][16];
  int cnt [3], phase [3], k [3], pos [3], pcd [3];
  logic [31:0] prog [3];
  function automatic int hld(int i);
    return i == 2 ? 3 : 2;
  endfunction
  function automatic bit lp(int i);
    return i == 1;
  endfunction
  function automatic int dp(int i);
    return i == 2 ? 4 : 16;
  endfunction
  function automatic string fname(int f);
    case (f)
      0: return "load_ready";
      1: return "core_rst";
      2: return "done";
      3: return "pc_idx";
      default: return "instruction";
    endcase
  endfunction
  function automatic logic [31:0] obs(int i, int f);
    case (f)
      0: return 32'(rdy[i]);
      1: return 32'(crst[i]);
      2: return 32'(dn[i]);
      3: return i == 0 ? 32'(pc_a) : i == 1 ? 32'(pc_b) : 32'(pc_c);
      default: return i == 0 ? instr_a : i == 1 ? instr_b : instr_c;
    endcase
  endfunction
  function automatic logic [31:0] expv(int i, int f);
    bit run;
    int pc;
    run = phase[i] == 1 && k[i] >= hld(i);
    pc = phase[i] == 2 ? pcd[i] : run ? (lp(i) ? pos[i] % cnt[i] : pos[i]) : 0;
    case (f)
      0: return 32'(phase[i] != 1);
      1: return 32'(phase[i] == 2 || run);
      2: return 32'(phase[i] == 2);
      3: return 32'(pc);
      default: return run ? mm[i][pc] : 32'h0000_0013;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic advance(input logic r, input logic lv, input int la, input logic [31:0] ld, input logic st, input logic sl);
    for (int i = 0; i < 3; i++) begin
      int old;
      old = cnt[i];
      if (!r) begin
        phase[i] = 0;
        cnt[i] = 0;
        pcd[i] = 0;
        k[i] = 0;
        pos[i] = 0;
      end else begin
        if (lv && la < dp(i) && phase[i] != 1) begin
          mm[i][la] = ld;
          if (la + 1 > cnt[i]) cnt[i] = la + 1;
        end
        if (phase[i] != 1) begin
          if (st && old != 0) begin
            phase[i] = 1;
            k[i] = 0;
            pos[i] = 0;
          end
        end else if (k[i] < hld(i)) k[i]++;
        else if (!sl) begin
          if (!lp(i) && pos[i] == cnt[i] - 1) begin
            phase[i] = 2;
            pcd[i] = pos[i];
          end else pos[i]++;
        end
      end
    end
  endtask
  task automatic step(input logic r, input logic lv, input int la, input logic [31:0] ld, input logic st, input logic sl);
    @(negedge clk);
    for (int i = 0; i < 3; i++)
      for (int f = 0; f < 5; f++)
        chk($sformatf("cfg%0d.%s", i, fname(f)), obs(i, f), expv(i, f));
    rst = r;
    load_valid = lv;
    load_addr = la[3:0];
    load_data = ld;
    start = st;
    stall = sl;
    advance(r, lv, la, ld, st, sl);
  endtask
  task automatic load_prog();
    for (int a = 0; a < 3; a++) step(1'b1, 1'b1, a, prog[a], 1'b0, 1'b0);
  endtask
  logic r, lv;
  int la;
  logic [3:0] stall_pat;
  initial begin
    prog = '{32'h0050_0093, 32'h0010_8113, 32'h0020_81B3};
    rst = 1'b0;
    load_valid = 1'b0;
    load_addr = '0;
    load_data = '0;
    start = 1'b0;
    stall = 1'b0;
    repeat (2) @(posedge clk);
    for (int a = 0; a < 16; a++) step(1'b1, 1'b1, a, $urandom, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (3) step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    load_prog();
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    load_prog();
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    stall_pat = 4'b0110;
    for (int c = 0; c < 12; c++) step(1'b1, 1'b0, 0, 0, c == 1, c < 4 ? stall_pat[c] : 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    load_prog();
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    for (int a = 0; a < 4; a++) step(1'b1, 1'b1, a, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    repeat (9) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 3, $urandom, 1'b0, 1'b0);
    step(1'b1, 1'b0, 0, 0, 1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    repeat (2500) begin
      r = $urandom_range(0, 59) != 0;
      lv = r && $urandom_range(0, 2) == 0;
      la = $urandom_range(0, 1) != 0 ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 15));
      step(r, lv, la, $urandom, $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0);
    end
    step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
